mult_div_unit: RTL

- Iterative MIPS HI/LO multiply/divide unit for the execute stage, directly downstream of the 32x32 register file.
- Consumes the two register read operands (rs, rt) and executes MULT, MULTU, DIV and DIVU.
- Holds the architectural HI/LO registers.
- HiOut/LoOut feed the writeback mux, so MFHI/MFLO results reach the register file write port. MTHI/MTLO load HI/LO directly.

---
 rtl/mult_div_unit.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative MIPS HI/LO multiply/divide unit
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] OperandA,
    input  logic [WIDTH-1:0] OperandB,
    input  logic [1:0]       MoveWrite,
    input  logic [WIDTH-1:0] MoveData,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] HiOut,
    output logic [WIDTH-1:0] LoOut
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     operand_q, operand_d;
    logic [WIDTH-1:0]     dividend_q, dividend_d;
    logic                 is_div_q, is_div_d;
    logic                 neg_res_q, neg_res_d;
    logic                 neg_rem_q, neg_rem_d;
    logic                 div_zero_q, div_zero_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic                 a_neg, b_neg;
    logic [WIDTH-1:0]     mag_a, mag_b;
    logic [WIDTH:0]       add_sum;
    logic [WIDTH:0]       div_shift;
    logic [WIDTH:0]       div_diff;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quot_fix, rem_fix;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        operand_d  = operand_q;
        dividend_d = dividend_q;
        is_div_d   = is_div_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        div_zero_d = div_zero_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;

        // Only MULT/DIV (Op[0]=0) treat operands as two's complement.
        a_neg = ~Op[0] & OperandA[WIDTH-1];
        b_neg = ~Op[0] & OperandB[WIDTH-1];
        mag_a = a_neg ? -OperandA : OperandA;
        mag_b = b_neg ? -OperandB : OperandB;

        add_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, operand_q};
        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, operand_q};

        prod_fix = neg_res_q ? -acc_q : acc_q;
        quot_fix = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    state_d    = S_CALC;
                    cnt_d      = '0;
                    is_div_d   = Op[1];
                    neg_res_d  = a_neg ^ b_neg;
                    neg_rem_d  = a_neg;
                    div_zero_d = Op[1] & (OperandB == '0);
                    dividend_d = OperandA;
                    // Multiply: lower half holds the multiplier; divide: lower half holds the dividend.
                    operand_d  = Op[1] ? mag_b : mag_a;
                    acc_d      = {{WIDTH{1'b0}}, Op[1] ? mag_a : mag_b};
                end else begin
                    if (MoveWrite[1]) hi_d = MoveData;
                    if (MoveWrite[0]) lo_d = MoveData;
                end
            end
            S_CALC: begin
                if (is_div_q) begin
                    if (div_diff[WIDTH])
                        acc_d = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                    else
                        acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                end else begin
                    if (acc_q[0])
                        acc_d = {add_sum, acc_q[WIDTH-1:1]};
                    else
                        acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == {CNT_W{1'b1}}) state_d = S_FIX;
            end
            S_FIX: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                if (!is_div_q) begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end else if (div_zero_q) begin
                    hi_d = dividend_q;
                    lo_d = {WIDTH{1'b1}};
                end else begin
                    hi_d = rem_fix;
                    lo_d = quot_fix;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            operand_q  <= '0;
            dividend_q <= '0;
            is_div_q   <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            operand_q  <= operand_d;
            dividend_q <= dividend_d;
            is_div_q   <= is_div_d;
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
            div_zero_q <= div_zero_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign Busy  = busy_q;
    assign Done  = done_q;
    assign HiOut = hi_q;
    assign LoOut = lo_q;

endmodule
